// File: rtl/sprite_pkg.sv
// Shared types, geometry constants and fixed-point helpers for the sprite rotate/raster block.
package sprite_pkg;

  localparam int SPRITE_DIM = 47;
  localparam int FRAC_BITS  = 4;
  localparam int ROT_W      = 8 + FRAC_BITS;
  localparam int ANG_W      = 13;
  localparam int COORD_W    = 6;
  localparam int DIM_W      = $clog2(SPRITE_DIM);
  localparam int CENTER     = (SPRITE_DIM - 1) / 2;
  localparam int PIX_W      = ROT_W + 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef logic        [COORD_W-1:0] coord_t;
  typedef logic signed [ROT_W-1:0]   rot_t;
  typedef logic signed [PIX_W-1:0]   pix_t;

  // Sprite-local coordinate to centred fixed-point operand.
  function automatic rot_t recentre(input coord_t v);
    logic signed [7:0] d;
    d = $signed({2'b00, v}) - $signed(8'(CENTER));
    return {d, {FRAC_BITS{1'b0}}};
  endfunction

  // Round half-up to integer, then shift back into plane coordinates.
  function automatic pix_t to_pixel(input rot_t v);
    pix_t s;
    s = PIX_W'(v) + PIX_W'(1 << (FRAC_BITS - 1));
    s = s >>> FRAC_BITS;
    return s + PIX_W'(CENTER);
  endfunction

  function automatic logic in_plane(input pix_t p);
    return !p[PIX_W-1] && (p < PIX_W'(SPRITE_DIM));
  endfunction

endpackage

// File: rtl/sprite_rotate_raster_frame_buf.sv
// Render plane with row clear, single-bit plot and registered row read.
// SPRITE_ROT_DOUBLE_BUF_EN adds a second plane that swaps front/back on request.
module sprite_frame_buf
  import sprite_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr_en_i,
  input  logic [DIM_W-1:0]      clr_row_i,
  input  logic                  plot_en_i,
  input  logic [DIM_W-1:0]      plot_x_i,
  input  logic [DIM_W-1:0]      plot_y_i,
`ifdef SPRITE_ROT_DOUBLE_BUF_EN
  input  logic                  swap_i,
`endif
  input  logic [DIM_W-1:0]      rd_row_i,
  output logic [SPRITE_DIM-1:0] rd_data_o
);

  logic wr_bank;
  logic rd_bank;

`ifdef SPRITE_ROT_DOUBLE_BUF_EN
  localparam int NB = 2;
  logic front_q;

  // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) front_q <= 1'b0;
    else if (swap_i) front_q <= ~front_q;
  end

  assign wr_bank = ~front_q;
  assign rd_bank = front_q;
`else
  localparam int NB = 1;
  assign wr_bank = 1'b0;
  assign rd_bank = 1'b0;
`endif

  logic [SPRITE_DIM-1:0] plane_q [NB][SPRITE_DIM];

  // NOTE: the plane is built from flops, not a RAM macro, so reset can clear it in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NB; b++)
        for (int r = 0; r < SPRITE_DIM; r++)
          plane_q[b][r] <= '0;
      rd_data_o <= '0;
    end else begin
      for (int b = 0; b < NB; b++)
        for (int r = 0; r < SPRITE_DIM; r++)
          if (wr_bank == 1'(b)) begin
            if (clr_en_i && clr_row_i == DIM_W'(r))
              plane_q[b][r] <= '0;
            else if (plot_en_i && plot_y_i == DIM_W'(r))
              plane_q[b][r][plot_x_i] <= 1'b1;
          end
      rd_data_o <= (rd_row_i < DIM_W'(SPRITE_DIM)) ? plane_q[rd_bank][rd_row_i] : '0;
    end
  end

endmodule

// File: rtl/sprite_rotate_raster.sv
// Sprite renderer: point ROM -> re-centre -> external rotator -> rounded plot into a bit-plane.
// SPRITE_ROT_DOUBLE_BUF_EN selects a double-buffered plane swapped on render completion.
module sprite_rotate_raster
  import sprite_pkg::*;
#(
  parameter int NUM_POINTS   = 416,
  parameter int PIPE_LATENCY = 19
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ANG_W-1:0]              theta,
  output logic [$clog2(NUM_POINTS)-1:0] pt_addr,
  input  logic [COORD_W-1:0]            pt_x,
  input  logic [COORD_W-1:0]            pt_y,
  input  logic                          pt_valid,
  output logic [ROT_W-1:0]              rot_x,
  output logic [ROT_W-1:0]              rot_y,
  output logic [ANG_W-1:0]              rot_a,
  input  logic [ROT_W-1:0]              rot_xo,
  input  logic [ROT_W-1:0]              rot_yo,
  input  logic [DIM_W-1:0]              line_sel,
  output logic [SPRITE_DIM-1:0]         line_data,
  output logic                          busy,
  output logic                          done,
  output logic [9:0]                    drop_cnt
);

  localparam int AW = $clog2(NUM_POINTS);
  localparam int VW = PIPE_LATENCY + 1;

  state_t            state_q;
  logic              busy_q, done_q;
  logic [AW-1:0]     addr_q;
  logic [DIM_W-1:0]  row_q;
  logic [ANG_W-1:0]  theta_q;
  logic              issue_q;
  logic [PIPE_LATENCY-1:0] occ_q;
  logic [VW-1:0]     vld_q;
  logic [ROT_W-1:0]  rot_x_q, rot_y_q;
  logic [9:0]        drop_q;
  logic              drain_empty;
  pix_t              px, py;
  logic              hit, miss;

  // In-flight tracking covers every issued slot, used or not, so drain time is fixed.
  assign drain_empty = !issue_q && (occ_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      row_q   <= '0;
      theta_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (start) begin
          theta_q <= theta;
          row_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= ST_CLEAR;
        end
        ST_CLEAR: begin
          row_q <= row_q + 1'b1;
          if (row_q == DIM_W'(SPRITE_DIM - 1)) begin
            row_q   <= '0;
            state_q <= ST_FEED;
          end
        end
        ST_FEED: begin
          if (addr_q == AW'(NUM_POINTS - 1)) begin
            addr_q  <= '0;
            state_q <= ST_DRAIN;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end
        ST_DRAIN: if (drain_empty) begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // ROM data arrives one cycle after issue; the valid tag rides alongside the rotator latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_q <= 1'b0;
      occ_q   <= '0;
      vld_q   <= '0;
      rot_x_q <= '0;
      rot_y_q <= '0;
    end else begin
      issue_q <= (state_q == ST_FEED);
      occ_q   <= PIPE_LATENCY'({occ_q, issue_q});
      vld_q   <= VW'({vld_q, issue_q & pt_valid});
      if (issue_q) begin
        rot_x_q <= recentre(pt_x);
        rot_y_q <= recentre(pt_y);
      end
    end
  end

  assign px   = to_pixel(rot_xo);
  assign py   = to_pixel(rot_yo);
  assign hit  = vld_q[VW-1] && in_plane(px) && in_plane(py);
  assign miss = vld_q[VW-1] && !(in_plane(px) && in_plane(py));

  always_ff @(posedge clk) begin
    if (reset) drop_q <= '0;
    else if (state_q == ST_IDLE && start) drop_q <= '0;
    else if (miss && drop_q != 10'h3FF) drop_q <= drop_q + 1'b1;
  end

  sprite_frame_buf u_frame_buf (
    .clk       (clk),
    .reset     (reset),
    .clr_en_i  (state_q == ST_CLEAR),
    .clr_row_i (row_q),
    .plot_en_i (hit),
    .plot_x_i  (px[DIM_W-1:0]),
    .plot_y_i  (py[DIM_W-1:0]),
`ifdef SPRITE_ROT_DOUBLE_BUF_EN
    .swap_i    (state_q == ST_DRAIN && drain_empty),
`endif
    .rd_row_i  (line_sel),
    .rd_data_o (line_data)
  );

  assign pt_addr  = addr_q;
  assign rot_x    = rot_x_q;
  assign rot_y    = rot_y_q;
  assign rot_a    = theta_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign drop_cnt = drop_q;

endmodule
